// File: rtl/mastermind_scorer.sv
// mastermind_scorer
//   Datapath stage behind the Mastermind control FSM. Holds the 4-peg secret
//   code and the current guess. On compare it scores the guess with a
//   multi-cycle colour-histogram scan: one cycle for exact matches, one cycle
//   per colour, and one cycle to publish. It also tracks the guess count and
//   the win / game-over state.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset (wins over every other input)
//   peg_in       colour of the peg being loaded
//   load_code    strobe: write peg_in to the next code slot (locked after 4)
//   load_guess   strobe: write peg_in to the next guess slot (needs full code)
//   compare      strobe: start scoring (needs full code and full guess)
//   busy         high while a score is being computed
//   score_valid  one-cycle pulse when black/white are updated
//   black        exact-position matches, 0..4 (held between scores)
//   white        colour-only matches, 0..4 (held between scores)
//   win          set when a score has black == 4
//   game_over    set on a win or once MAX_GUESSES guesses are scored
//   guess_count  number of scored guesses (saturates at 15)
//
// Optional build macro MASTERMIND_SCORER_HEX_EN adds hex_black / hex_white,
// registered active-low 7-segment images of black / white (7'h7F after reset).

module mastermind_scorer #(
    parameter int PEG_W       = 3,
    parameter int MAX_GUESSES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PEG_W-1:0] peg_in,
    input  logic             load_code,
    input  logic             load_guess,
    input  logic             compare,
    output logic             busy,
    output logic             score_valid,
    output logic [2:0]       black,
    output logic [2:0]       white,
    output logic             win,
    output logic             game_over,
    output logic [3:0]       guess_count
`ifdef MASTERMIND_SCORER_HEX_EN
    ,
    output logic [6:0]       hex_black,
    output logic [6:0]       hex_white
`endif
);

    localparam logic [PEG_W-1:0] LAST_COLOR    = PEG_W'((1 << PEG_W) - 1);
    localparam logic [PEG_W-1:0] COLOR_ONE     = PEG_W'(1);
    localparam logic [PEG_W-1:0] COLOR_ZERO    = PEG_W'(0);
    localparam logic [4:0]       MAX_GUESSES_C = 5'(MAX_GUESSES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BLACK = 3'd1,
        ST_WHITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [PEG_W-1:0] code_r  [4];
    logic [PEG_W-1:0] guess_r [4];
    logic [1:0]       code_slot_r;
    logic [1:0]       guess_slot_r;
    logic             code_full_r;
    logic             guess_full_r;
    logic [2:0]       black_acc_r;
    logic [2:0]       total_r;
    logic [PEG_W-1:0] color_r;
    logic [2:0]       exact_s;
    logic [2:0]       code_cnt_s;
    logic [2:0]       guess_cnt_s;
    logic [2:0]       color_min_s;
    logic [4:0]       guess_inc_s;
    logic             last_guess_s;
    logic             win_now_s;
    logic             busy_next_s;

`ifdef MASTERMIND_SCORER_HEX_EN
    // Active-low segments {g,f,e,d,c,b,a}; only 0..4 can occur, anything else blanks.
    function automatic logic [6:0] seg7_n(input logic [2:0] value);
        logic [6:0] seg;
        case (value)
            3'd0:    seg = 7'h40;
            3'd1:    seg = 7'h79;
            3'd2:    seg = 7'h24;
            3'd3:    seg = 7'h30;
            3'd4:    seg = 7'h19;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction
`endif

    // Exact matches and the per-colour histogram minimum for the colour under scan.
    always_comb begin
        exact_s     = 3'd0;
        code_cnt_s  = 3'd0;
        guess_cnt_s = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (code_r[i] == guess_r[i]) exact_s = exact_s + 3'd1;
            else                         exact_s = exact_s;
            if (code_r[i] == color_r)    code_cnt_s = code_cnt_s + 3'd1;
            else                         code_cnt_s = code_cnt_s;
            if (guess_r[i] == color_r)   guess_cnt_s = guess_cnt_s + 3'd1;
            else                         guess_cnt_s = guess_cnt_s;
        end
        color_min_s  = (code_cnt_s < guess_cnt_s) ? code_cnt_s : guess_cnt_s;
        guess_inc_s  = {1'b0, guess_count} + 5'd1;
        last_guess_s = (guess_inc_s == MAX_GUESSES_C);
        win_now_s    = (black_acc_r == 3'd4);
    end

    // Next-state logic of the scoring sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (compare && code_full_r && guess_full_r && !game_over) state_next_s = ST_BLACK;
                else                                                      state_next_s = ST_IDLE;
            end
            ST_BLACK: state_next_s = ST_WHITE;
            ST_WHITE: begin
                if (color_r == LAST_COLOR) state_next_s = ST_DONE;
                else                       state_next_s = ST_WHITE;
            end
            ST_DONE: begin
                if (win_now_s || last_guess_s) state_next_s = ST_OVER;
                else                           state_next_s = ST_IDLE;
            end
            ST_OVER: state_next_s = ST_OVER;
            default: state_next_s = ST_IDLE;
        endcase
        busy_next_s = (state_next_s == ST_BLACK) || (state_next_s == ST_WHITE) ||
                      (state_next_s == ST_DONE);
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // Peg storage, scan accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                code_r[i]  <= COLOR_ZERO;
                guess_r[i] <= COLOR_ZERO;
            end
            code_slot_r  <= 2'd0;
            guess_slot_r <= 2'd0;
            code_full_r  <= 1'b0;
            guess_full_r <= 1'b0;
            black_acc_r  <= 3'd0;
            total_r      <= 3'd0;
            color_r      <= COLOR_ZERO;
            busy         <= 1'b0;
            score_valid  <= 1'b0;
            black        <= 3'd0;
            white        <= 3'd0;
            win          <= 1'b0;
            game_over    <= 1'b0;
            guess_count  <= 4'd0;
`ifdef MASTERMIND_SCORER_HEX_EN
            hex_black    <= 7'h7F;
            hex_white    <= 7'h7F;
`endif
        end else begin
            // busy/game_over follow the state being entered so they line up with it.
            busy        <= busy_next_s;
            game_over   <= (state_next_s == ST_OVER);
            score_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // load_code takes priority; a coincident load_guess is dropped.
                    if (load_code) begin
                        if (!code_full_r) begin
                            code_r[code_slot_r] <= peg_in;
                            code_slot_r         <= code_slot_r + 2'd1;
                            code_full_r         <= (code_slot_r == 2'd3);
                        end
                    end else if (load_guess && code_full_r && !guess_full_r) begin
                        guess_r[guess_slot_r] <= peg_in;
                        guess_slot_r          <= guess_slot_r + 2'd1;
                        guess_full_r          <= (guess_slot_r == 2'd3);
                    end
                end
                ST_BLACK: begin
                    black_acc_r <= exact_s;
                    total_r     <= 3'd0;
                    color_r     <= COLOR_ZERO;
                end
                ST_WHITE: begin
                    total_r <= total_r + color_min_s;
                    color_r <= color_r + COLOR_ONE;
                end
                ST_DONE: begin
                    // total counts every colour match, so it never drops below black_acc_r.
                    score_valid  <= 1'b1;
                    black        <= black_acc_r;
                    white        <= total_r - black_acc_r;
                    win          <= win_now_s;
                    guess_count  <= (guess_count == 4'd15) ? guess_count : guess_count + 4'd1;
                    guess_full_r <= 1'b0;
                    guess_slot_r <= 2'd0;
`ifdef MASTERMIND_SCORER_HEX_EN
                    hex_black    <= seg7_n(black_acc_r);
                    hex_white    <= seg7_n(total_r - black_acc_r);
`endif
                end
                ST_OVER: begin
                    code_full_r <= code_full_r;
                end
                default: begin
                    code_full_r <= code_full_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mastermind_scorer.sv
module tb_mastermind_scorer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] peg_in;
    logic       load_code;
    logic       load_guess;
    logic       compare;
    logic       busy;
    logic       score_valid;
    logic [2:0] black;
    logic [2:0] white;
    logic       win;
    logic       game_over;
    logic [3:0] guess_count;
`ifdef MASTERMIND_SCORER_HEX_EN
    logic [6:0] hex_black;
    logic [6:0] hex_white;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mastermind_scorer #(.PEG_W(3), .MAX_GUESSES(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .peg_in      (peg_in),
        .load_code   (load_code),
        .load_guess  (load_guess),
        .compare     (compare),
        .busy        (busy),
        .score_valid (score_valid),
        .black       (black),
        .white       (white),
        .win         (win),
        .game_over   (game_over),
        .guess_count (guess_count)
`ifdef MASTERMIND_SCORER_HEX_EN
        ,
        .hex_black   (hex_black),
        .hex_white   (hex_white)
`endif
    );

    // Pack four pegs, first-loaded peg in the low bits.
    function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
        logic [2:0] pa, pb, pc, pd;
        pa = 3'(a); pb = 3'(b); pc = 3'(c); pd = 3'(d);
        return {pd, pc, pb, pa};
    endfunction

    // Classic Mastermind scoring by marking matched pegs.
    function automatic void ref_score(input logic [11:0] code, input logic [11:0] guess,
                                      output int b, output int w);
        bit cu [4];
        bit gu [4];
        b = 0;
        w = 0;
        for (int i = 0; i < 4; i++) begin cu[i] = 1'b0; gu[i] = 1'b0; end
        for (int i = 0; i < 4; i++)
            if (code[3*i +: 3] == guess[3*i +: 3]) begin b++; cu[i] = 1'b1; gu[i] = 1'b1; end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (!gu[i] && !cu[j] && code[3*j +: 3] == guess[3*i +: 3]) begin
                    w++; cu[j] = 1'b1; gu[i] = 1'b1;
                end
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic strobe_code(input logic [2:0] p);
        peg_in = p; load_code = 1'b1;
        @(negedge clk);
        load_code = 1'b0;
    endtask

    task automatic strobe_guess(input logic [2:0] p);
        peg_in = p; load_guess = 1'b1;
        @(negedge clk);
        load_guess = 1'b0;
    endtask

    task automatic send_code(input logic [11:0] c);
        for (int i = 0; i < 4; i++) strobe_code(c[3*i +: 3]);
    endtask

    task automatic send_guess(input logic [11:0] g);
        for (int i = 0; i < 4; i++) strobe_guess(g[3*i +: 3]);
    endtask

    // Pulse compare, then watch 14 cycles; optionally re-pulse compare mid-scan.
    task automatic run_score(input bit inject, output int pulses, output int lat,
                             output logic [2:0] b, output logic [2:0] w, output logic busy0);
        pulses = 0; lat = -1; b = 3'd0; w = 3'd0;
        compare = 1'b1;
        @(negedge clk);
        compare = 1'b0;
        busy0 = busy;
        for (int n = 0; n < 14; n++) begin
            if (score_valid) begin
                pulses++;
                if (lat < 0) begin lat = n; b = black; w = white; end
            end
            compare = inject && (n == 2);
            @(negedge clk);
        end
        compare = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, score_valid, black, white, win, game_over, guess_count} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {busy, score_valid, black, white, win, game_over, guess_count});
        end
`ifdef MASTERMIND_SCORER_HEX_EN
        checks++;
        if ({hex_black, hex_white} !== 14'h3FFF) begin
            errors++;
            $display("FAIL reset_hex: got %h/%h expected 7f/7f", hex_black, hex_white);
        end
`endif
    endtask

    task automatic test_win();
        int p, l; logic [2:0] b, w; logic b0;
        do_reset();
        send_code(pk(1, 2, 3, 4));
        strobe_code(3'd7);  // code is locked, must be ignored
        send_guess(pk(1, 2, 3, 4));
        run_score(1'b0, p, l, b, w, b0);
        checks++;
        if (p != 1 || l != 10 || b0 !== 1'b1) begin
            errors++; $display("FAIL win_latency: pulses=%0d lat=%0d busy=%b expected 1/10/1", p, l, b0);
        end
        checks++;
        if (b !== 3'd4 || w !== 3'd0) begin
            errors++; $display("FAIL win_score: got b=%0d w=%0d expected 4/0", b, w);
        end
        checks++;
        if (win !== 1'b1 || game_over !== 1'b1 || guess_count !== 4'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL win_flags: win=%b over=%b gc=%0d busy=%b expected 1/1/1/0",
                     win, game_over, guess_count, busy);
        end
`ifdef MASTERMIND_SCORER_HEX_EN
        checks++;
        if (hex_black !== 7'h19 || hex_white !== 7'h40) begin
            errors++; $display("FAIL win_hex: got %h/%h expected 19/40", hex_black, hex_white);
        end
`endif
    endtask

    task automatic test_reverse();
        int p, l; logic [2:0] b, w; logic b0;
        do_reset();
        send_code(pk(1, 2, 3, 4));
        peg_in = 3'd7; load_code = 1'b1; load_guess = 1'b1;  // guess strobe dropped
        @(negedge clk);
        load_code = 1'b0; load_guess = 1'b0;
        send_guess(pk(4, 3, 2, 1));
        strobe_guess(3'd7);  // guess already full, ignored
        run_score(1'b0, p, l, b, w, b0);
        checks++;
        if (p != 1 || b !== 3'd0 || w !== 3'd4) begin
            errors++; $display("FAIL reverse_score: pulses=%0d b=%0d w=%0d expected 1/0/4", p, b, w);
        end
        checks++;
        if (win !== 1'b0 || game_over !== 1'b0 || busy !== 1'b0 || guess_count !== 4'd1) begin
            errors++;
            $display("FAIL reverse_flags: win=%b over=%b busy=%b gc=%0d expected 0/0/0/1",
                     win, game_over, busy, guess_count);
        end
        send_guess(pk(1, 2, 3, 5));
        run_score(1'b0, p, l, b, w, b0);
        checks++;
        if (p != 1 || b !== 3'd3 || w !== 3'd0 || guess_count !== 4'd2) begin
            errors++;
            $display("FAIL second_guess: pulses=%0d b=%0d w=%0d gc=%0d expected 1/3/0/2", p, b, w, guess_count);
        end
    endtask

    task automatic test_duplicates();
        int p, l; logic [2:0] b, w; logic b0;
        do_reset();
        send_code(pk(1, 1, 2, 2));
        send_guess(pk(1, 2, 1, 1));
        run_score(1'b0, p, l, b, w, b0);
        checks++;
        if (p != 1 || b !== 3'd1 || w !== 3'd2) begin
            errors++; $display("FAIL duplicates: pulses=%0d b=%0d w=%0d expected 1/1/2", p, b, w);
        end
    endtask

    task automatic test_partial_and_busy();
        int p, l; logic [2:0] b, w; logic b0;
        do_reset();
        send_code(pk(5, 6, 7, 0));
        strobe_guess(3'd5); strobe_guess(3'd7); strobe_guess(3'd6);
        run_score(1'b0, p, l, b, w, b0);
        checks++;
        if (p != 0 || b0 !== 1'b0) begin
            errors++; $display("FAIL partial_guess: pulses=%0d busy=%b expected 0/0", p, b0);
        end
        strobe_guess(3'd1);
        run_score(1'b1, p, l, b, w, b0);
        checks++;
        if (p != 1 || l != 10 || b !== 3'd1 || w !== 3'd2) begin
            errors++;
            $display("FAIL compare_during_busy: pulses=%0d lat=%0d b=%0d w=%0d expected 1/10/1/2", p, l, b, w);
        end
    endtask

    task automatic test_game_over();
        int p, l; logic [2:0] b, w; logic b0;
        do_reset();
        send_code(pk(0, 0, 0, 0));
        for (int g = 1; g <= 10; g++) begin
            send_guess(pk(7, 7, 7, 7));
            run_score(1'b0, p, l, b, w, b0);
            checks++;
            if (p != 1 || b !== 3'd0 || w !== 3'd0 || guess_count !== 4'(g) ||
                game_over !== (g == 10)) begin
                errors++;
                $display("FAIL game_over_seq%0d: pulses=%0d b=%0d w=%0d gc=%0d over=%b expected 1/0/0/%0d/%0d",
                         g, p, b, w, guess_count, game_over, g, (g == 10));
            end
        end
        send_guess(pk(0, 0, 0, 0));
        run_score(1'b0, p, l, b, w, b0);
        checks++;
        if (p != 0 || b0 !== 1'b0 || guess_count !== 4'd10 || game_over !== 1'b1 || win !== 1'b0) begin
            errors++;
            $display("FAIL after_over: pulses=%0d busy=%b gc=%0d over=%b win=%b expected 0/0/10/1/0",
                     p, b0, guess_count, game_over, win);
        end
    endtask

    task automatic test_reset_mid_scan();
        int p, l; logic [2:0] b, w; logic b0;
        do_reset();
        send_code(pk(1, 2, 3, 4));
        send_guess(pk(1, 2, 3, 5));
        run_score(1'b0, p, l, b, w, b0);
        send_guess(pk(2, 1, 3, 5));
        compare = 1'b1;
        @(negedge clk);
        compare = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, score_valid, black, white, win, game_over, guess_count} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid_scan: got %b expected all zero",
                     {busy, score_valid, black, white, win, game_over, guess_count});
        end
        send_guess(pk(1, 2, 3, 4));
        run_score(1'b0, p, l, b, w, b0);
        checks++;
        if (p != 0 || b0 !== 1'b0) begin
            errors++; $display("FAIL code_cleared: pulses=%0d busy=%b expected 0/0", p, b0);
        end
    endtask

    task automatic test_random();
        int p, l, eb, ew, gc; logic [2:0] b, w; logic b0;
        logic [11:0] code, guess;
        bit over;
        for (int game = 0; game < 8; game++) begin
            do_reset();
            code = 12'($urandom);
            send_code(code);
            gc = 0;
            over = 1'b0;
            while (!over) begin
                guess = ($urandom_range(0, 3) == 0) ? code : 12'($urandom);
                ref_score(code, guess, eb, ew);
                send_guess(guess);
                run_score(1'b0, p, l, b, w, b0);
                gc++;
                over = (eb == 4) || (gc == 10);
                checks++;
                if (p != 1 || l != 10 || b !== 3'(eb) || w !== 3'(ew) || guess_count !== 4'(gc) ||
                    win !== (eb == 4) || game_over !== over) begin
                    errors++;
                    $display("FAIL random_g%0d_n%0d: pulses=%0d lat=%0d b=%0d w=%0d gc=%0d win=%b over=%b expected 1/10/%0d/%0d/%0d/%0d/%0d",
                             game, gc, p, l, b, w, guess_count, win, game_over,
                             eb, ew, gc, (eb == 4), over);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; peg_in = 3'd0; load_code = 1'b0; load_guess = 1'b0; compare = 1'b0;
        @(negedge clk);
        test_reset();
        test_win();
        test_reverse();
        test_duplicates();
        test_partial_and_busy();
        test_game_over();
        test_reset_mid_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mastermind_scorer.md
Name: mastermind_scorer

Overview:
- Datapath stage directly downstream of the Mastermind control FSM. It consumes the FSM's load_code, load_guess and compare strobes, together with the peg colour from the switches.
- Stores the 4-peg secret code and the current guess.
- Computes the black count (right colour, right position) and the white count (right colour, wrong position) with a multi-cycle colour-histogram scan.
- Tracks the guess count and the win / game-over conditions.

Parameters:
- PEG_W, 3: bits per peg colour; 2^PEG_W colours (8 by default).
- MAX_GUESSES, 10: number of scored guesses before game_over; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- peg_in  in  PEG_W  colour of the peg being loaded
- load_code  in  1  one-cycle strobe; writes peg_in to the next code slot
- load_guess  in  1  one-cycle strobe; writes peg_in to the next guess slot
- compare  in  1  one-cycle strobe; starts scoring
- busy  out  1  high while scoring is in progress
- score_valid  out  1  one-cycle pulse; black and white are updated
- black  out  3  exact-position matches, 0..4
- white  out  3  colour-only matches, 0..4
- win  out  1  set when black==4
- game_over  out  1  set on win or when guess_count reaches MAX_GUESSES
- guess_count  out  4  number of scored guesses

Behaviour:
- Reset: every output is 0. Code and guess registers, slot counters, code_full, guess_full and the FSM are cleared; the FSM returns to IDLE. Reset applies from any state, including mid-scan, and takes priority over every other input.
- Code load: each load_code while in IDLE writes peg_in to code slot code_slot (0..3), then increments code_slot. The 4th write sets code_full. Further load_code strobes are ignored until reset (the code is locked).
- Guess load: load_guess while in IDLE and code_full writes the guess slot (0..3) and increments guess_slot. The 4th write sets guess_full. Extra strobes while guess_full are ignored. load_guess before code_full is ignored.
- Simultaneous load_code and load_guess: load_code wins and load_guess is dropped.
- Strobes are level-sampled each cycle. The upstream FSM guarantees one-cycle pulses; a held strobe loads one peg per cycle.
- FSM states: IDLE, BLACK, WHITE, DONE, OVER.
  - IDLE: compare with code_full and guess_full and not game_over goes to BLACK. Otherwise compare is ignored.
  - BLACK (1 cycle): black_r = number of positions i with code[i]==guess[i]. Clears the total accumulator and sets colour index c=0.
  - WHITE (2^PEG_W cycles): for colour c, cc = occurrences of c in code and gc = occurrences of c in guess. total += min(cc,gc). Then c++. Exit to DONE after c==2^PEG_W-1.
  - DONE (1 cycle):
    - Update outputs: black = black_r, white = total - black_r, score_valid = 1.
    - Increment guess_count (saturating at 15) and clear guess_full and guess_slot.
    - Set win if black_r==4.
    - Next state is OVER if win or guess_count+1 == MAX_GUESSES; otherwise IDLE.
  - OVER: game_over = 1. All strobes are ignored; the block stays here until reset.
- busy = 1 in BLACK, WHITE and DONE.
- Latency: compare sampled at edge k means score_valid is high in the cycle after edge k+2^PEG_W+2 (10 edges for PEG_W=3).
- compare, load_code and load_guess are all ignored while busy.
- black and white hold their value between scores.
- Widths: per-colour counts are 3 bits and total is 3 bits (max 4). The subtraction never underflows because total >= black_r.

Optional Feature:
- Macro: MASTERMIND_SCORER_HEX_EN.
- When defined, adds outputs hex_black[6:0] and hex_white[6:0]. These are registered active-low 7-segment encodings of black and white, updated in the same cycle as black and white, and showing all-off (7'h7F) after reset.
- When undefined, the ports and the decoder logic do not exist; all other behaviour is identical.

Test Plan:
- Code 1,2,3,4; guess 1,2,3,4; compare -> score_valid 10 cycles later; black=4, white=0, win=1, game_over=1, guess_count=1.
- Code 1,2,3,4; guess 4,3,2,1 -> black=0, white=4, win=0; FSM back in IDLE.
- Code 1,1,2,2; guess 1,2,1,1 -> black=1, white=2 (duplicate handling).
- Only 3 guess pegs loaded, then compare -> no busy, no score_valid. 4th load plus compare -> scores normally. A compare pulse during busy -> ignored; exactly one score_valid.
- MAX_GUESSES=10; code 0,0,0,0; ten guesses 7,7,7,7 -> black=0, white=0 each time; game_over after the 10th score. An 11th compare produces no response.
- Reset asserted mid-WHITE -> next cycle busy=0 and all outputs 0; code must be reloaded. With MASTERMIND_SCORER_HEX_EN: hex_black is the "4" pattern (7'h19) after a winning score.
